// File: rtl/router_pkg.sv
// Shared router constants: dual-rail token encoding, route-to-select mapping and FSM states.
package router_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_NULL = 2'd2;

    function automatic logic [1:0] dr_token(input logic b);
        return b ? DR_1 : DR_0;
    endfunction

    // Route 0 selects R0 (rail 0), route 1 selects R1 (rail 1).
    function automatic logic [1:0] route_sel(input logic r);
        return r ? DR_1 : DR_0;
    endfunction

endpackage

// File: rtl/ack_sync.sv
// Two-flop enable synchronizer, reset to 1; only built when ROUTE_ACK_SYNC_EN is defined.
`ifdef ROUTE_ACK_SYNC_EN
module ack_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/route_token_gen.sv
// Clocked flit to dual-rail token bridge feeding the PCHB split stage.
// ROUTE_ACK_SYNC_EN: when defined, Le/sele are observed through 2-flop synchronizers.
module route_token_gen
    import router_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DST_BIT = WIDTH - 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_head,
    input  logic             in_tail,
    output logic [1:0]       L,
    input  logic             Le,
    output logic [1:0]       sel,
    input  logic             sele,
    output logic             err
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic             le_obs;
    logic             sele_obs;
    logic [1:0]       state_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] data_q;
    logic             route_q;
    logic             route_new;
    logic             open_q;
    logic             tail_q;
    logic             err_q;
    logic [1:0]       l_q;
    logic [1:0]       sel_q;
    logic             accept;

`ifdef ROUTE_ACK_SYNC_EN
    ack_sync u_le_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (Le),
        .q     (le_obs)
    );

    ack_sync u_sele_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (sele),
        .q     (sele_obs)
    );
`else
    assign le_obs   = Le;
    assign sele_obs = sele;
`endif

    // Gated by RESET so the block never advertises readiness while held in reset.
    assign in_ready  = RESET && (state_q == ST_IDLE) && le_obs && sele_obs;
    assign accept    = in_valid && in_ready;
    assign idx_nxt   = idx_q + IW'(1);
    assign last_bit  = (idx_q == IW'(WIDTH - 1));
    assign route_new = in_head ? in_data[DST_BIT] : route_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            route_q <= 1'b0;
            open_q  <= 1'b0;
            tail_q  <= 1'b0;
            err_q   <= 1'b0;
            l_q     <= DR_NULL;
            sel_q   <= DR_NULL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_head || open_q) begin
                            data_q  <= in_data;
                            tail_q  <= in_tail;
                            route_q <= route_new;
                            open_q  <= 1'b1;
                            idx_q   <= '0;
                            l_q     <= dr_token(in_data[0]);
                            sel_q   <= route_sel(route_new);
                            state_q <= ST_DATA;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // Both enables must fall; a single fallen enable just holds the token.
                    if (!le_obs && !sele_obs) begin
                        l_q     <= DR_NULL;
                        sel_q   <= DR_NULL;
                        state_q <= ST_NULL;
                    end
                end
                ST_NULL: begin
                    if (le_obs && sele_obs) begin
                        if (!last_bit) begin
                            idx_q   <= idx_nxt;
                            l_q     <= dr_token(data_q[idx_nxt]);
                            sel_q   <= route_sel(route_q);
                            state_q <= ST_DATA;
                        end else begin
                            if (tail_q) begin
                                open_q <= 1'b0;
                            end
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    l_q     <= DR_NULL;
                    sel_q   <= DR_NULL;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign L   = l_q;
    assign sel = sel_q;
    assign err = err_q;

endmodule

// File: tb/tb_route_token_gen.sv
// Directed self-checking bench for route_token_gen (WIDTH=4, enables sampled directly).
module tb_route_token_gen;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_head;
    logic       in_tail;
    logic [1:0] L;
    logic       Le;
    logic [1:0] sel;
    logic       sele;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    route_token_gen #(.WIDTH(4), .DST_BIT(3)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_head  (in_head),
        .in_tail  (in_tail),
        .L        (L),
        .Le       (Le),
        .sel      (sel),
        .sele     (sele),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) on negedges until L is NULL (want_null=1) or carries data.
    task automatic wait_l(input bit want_null, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if ((L == 2'b00) == want_null) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Act as the split for one token: consume data, then return to ready.
    task automatic do_token(input logic [1:0] exp_l, input logic [1:0] exp_sel, input bit skew,
                            input string tag);
        bit ok;
        wait_l(1'b0, ok);
        check_val({tag, "_data_wait"}, 32'(ok), 32'd1);
        check_val({tag, "_L"}, 32'(L), 32'(exp_l));
        check_val({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        if (skew) begin
            Le = 1'b0;
            repeat (3) @(negedge CLK);
            check_val({tag, "_skew_hold_L"}, 32'(L), 32'(exp_l));
            check_val({tag, "_skew_hold_sel"}, 32'(sel), 32'(exp_sel));
            sele = 1'b0;
            @(negedge CLK);
            check_val({tag, "_skew_null_L"}, 32'(L), 32'd0);
        end else begin
            Le   = 1'b0;
            sele = 1'b0;
            wait_l(1'b1, ok);
            check_val({tag, "_null_wait"}, 32'(ok), 32'd1);
        end
        check_val({tag, "_null_sel"}, 32'(sel), 32'd0);
        Le   = 1'b1;
        sele = 1'b1;
    endtask

    task automatic send_flit(input logic [3:0] d, input logic h, input logic t, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({tag, "_ready_wait"}, 32'(ok), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_head  = h;
        in_tail  = t;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_head  = 1'b0;
        in_tail  = 1'b0;
    endtask

    // exp_seq holds token i at [2i+1:2i]; skew_idx selects the token whose enables fall apart.
    task automatic run_flit(input logic [3:0] d, input logic h, input logic t,
                            input logic [7:0] exp_seq, input logic [1:0] exp_sel,
                            input int skew_idx, input string tag);
        send_flit(d, h, t, tag);
        for (int i = 0; i < 4; i++) begin
            do_token(exp_seq[2*i +: 2], exp_sel, (i == skew_idx), $sformatf("%s_t%0d", tag, i));
        end
    endtask

    initial begin
        bit ok;
        RESET    = 1'b0;
        Le       = 1'b1;
        sele     = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_head  = 1'b0;
        in_tail  = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_L", 32'(L), 32'd0);
        check_val("rst_sel", 32'(sel), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check_val("post_rst_ready", 32'(in_ready), 32'd1);

        // Single-flit packet 1011: tokens 10,10,01,10 on route 1.
        run_flit(4'b1011, 1'b1, 1'b1, 8'b10_01_10_10, 2'b10, -1, "ht1011");
        @(negedge CLK);
        check_val("ht_idle_ready", 32'(in_ready), 32'd1);
        check_val("ht_open", 32'(dut.open_q), 32'd0);

        // Non-head flit with no open packet is dropped.
        send_flit(4'b1111, 1'b0, 1'b0, "orphan");
        @(negedge CLK);
        check_val("orphan_err", 32'(err), 32'd1);
        check_val("orphan_L", 32'(L), 32'd0);
        repeat (3) @(negedge CLK);
        check_val("orphan_L_later", 32'(L), 32'd0);
        check_val("orphan_ready", 32'(in_ready), 32'd1);

        // Two-flit packet on route 0; Le falls 3 cycles early on head token 1.
        run_flit(4'b0001, 1'b1, 1'b0, 8'b01_01_01_10, 2'b01, 1, "head0001");
        run_flit(4'b0110, 1'b0, 1'b1, 8'b01_10_10_01, 2'b01, -1, "tail0110");
        @(negedge CLK);
        check_val("pkt2_open", 32'(dut.open_q), 32'd0);
        check_val("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a packet.
        send_flit(4'b1000, 1'b1, 1'b0, "mid");
        do_token(2'b01, 2'b10, 1'b0, "mid_t0");
        wait_l(1'b0, ok);
        check_val("mid_t1_wait", 32'(ok), 32'd1);
        check_val("mid_t1_sel", 32'(sel), 32'd2);
        RESET = 1'b0;
        @(negedge CLK);
        check_val("midrst_L", 32'(L), 32'd0);
        check_val("midrst_sel", 32'(sel), 32'd0);
        check_val("midrst_open", 32'(dut.open_q), 32'd0);
        check_val("midrst_err", 32'(err), 32'd0);
        check_val("midrst_ready", 32'(in_ready), 32'd0);
        RESET = 1'b1;

        // Fresh head after reset takes route 0 from bit 3.
        run_flit(4'b0101, 1'b1, 1'b1, 8'b01_10_01_10, 2'b01, -1, "fresh0101");
        @(negedge CLK);
        check_val("fresh_open", 32'(dut.open_q), 32'd0);
        check_val("fresh_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/route_token_gen.md
# route_token_gen

Synchronous-to-dual-rail bridge sitting directly upstream of the PCHB split stage in the async router. Accepts clocked packet flits, latches the route from the head flit, serializes each flit LSB-first into 1-bit dual-rail data tokens on `L`, and pairs each token with a dual-rail route token on `sel`. All tokens follow four-phase return-to-zero signalling against the split's `Le`/`sele` enables.

## Interface
- `WIDTH`, 4: flit width in bits, ≥2; also the number of tokens per flit.
- `DST_BIT`, WIDTH-1: bit index in the head flit that carries the destination (0 → R0, 1 → R1).
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: reset, synchronous and active-low.
- `in_valid` input 1: upstream flit valid.
- `in_ready` output 1: block accepts a flit this cycle.
- `in_data` input WIDTH: flit payload.
- `in_head` input 1: flit is a packet head; route is taken from `in_data[DST_BIT]`.
- `in_tail` input 1: flit closes the packet.
- `L` output 2: dual-rail data token to the split.
- `Le` input 1: split data enable; high = ready for data, low = data consumed.
- `sel` output 2: dual-rail route token to the split.
- `sele` input 1: split select enable; same meaning as `Le`.
- `err` output 1: sticky flag; a non-head flit arrived with no open packet.

## Operation
- Encoding: NULL=00, logic 0=01, logic 1=10. Route 0 drives `sel`=01 (R0); route 1 drives `sel`=10 (R1).
- FSM states: IDLE, DATA, NULL.
- IDLE:
  - `in_ready` = 1 only when the observed `Le`=1 and `sele`=1.
  - On `in_valid && in_ready`: latch the flit, bit index ← 0, go to DATA.
  - A head flit sets `open`=1 and latches the route. A head flit while `open`=1 re-routes.
  - A non-head flit with `open`=0 is dropped, sets `err`=1, and the FSM stays in IDLE.
- DATA: drive `L` = token(bit[idx]) and `sel` = route token. When the observed `Le`=0 AND `sele`=0, go to NULL. If only one enable has fallen, hold and keep waiting.
- NULL: drive `L`=`sel`=00. When the observed `Le`=1 AND `sele`=1:
  - If idx < WIDTH-1: idx+1, go to DATA.
  - Otherwise go to IDLE; clear `open` if the flit was a tail.
- Head+tail on one flit is a single-flit packet.
- Reset values: `L`=00, `sel`=00, `in_ready`=0 during reset, `err`=0, `open`=0, state IDLE, idx=0.
- Reset mid-packet: the current token is abandoned and outputs go to NULL at the next edge. The split must be reset in the same window.

## Timing
- `L`/`sel` are registered; they never glitch and change only on the `CLK` edge.
- Data token appears the cycle after flit acceptance.
- Without sync: the DATA→NULL transition occurs the cycle after both enables are sampled low. NULL→DATA (or IDLE) occurs the cycle after both are sampled high.
- `ROUTE_ACK_SYNC_EN` adds 2 cycles to every enable observation.
- Minimum cycles per flit: 2·WIDTH (no sync); 2·WIDTH + 4·WIDTH (sync).
- `in_ready` is combinational from state and the observed enables. It never depends on `in_valid`.
- `L` and `sel` always transition together (both data or both NULL).

## Configuration
- `ROUTE_ACK_SYNC_EN`:
  - Defined: `Le` and `sele` each pass through a 2-flop synchronizer reset to 1. "Observed" means the synchronizer output.
  - Undefined: enables are sampled directly. Use this only for zero-delay simulation against the split model.

## Structure
- `router_pkg` holds the dual-rail constants (`DR_NULL`, `DR_0`, `DR_1`), the route-to-`sel` encoding, and the FSM state enum shared with the downstream merge stages.
- Sub-module `ack_sync`: 2-flop synchronizer instantiated twice, compiled only under the macro.

## Test plan
- Reset with `RESET`=0 for 2 cycles, enables high → `L`=`sel`=00, `err`=0, `in_ready`=1 after release.
- Head+tail flit `in_data`=4'b1011 (DST_BIT=3 → route 1), split responds correctly → `L` sequence 10,00,10,00,01,00,10,00, `sel`=10 on every data phase, returns to IDLE, `open`=0.
- Head 4'b0001 then tail 4'b0110 → all 8 data tokens carry `sel`=01. The tail bits arrive as 01,10,10,01 on `L`.
- `Le` falls 3 cycles before `sele` → FSM holds DATA with outputs stable until `sele` falls, then NULL.
- Non-head flit with no open packet → dropped, `err`=1 and sticky, no token emitted.
- Assert `RESET`=0 during a DATA phase of a 4-flit packet → next edge `L`=`sel`=00, `open`=0. The next head flit is routed fresh.
